// File: rtl/pg_ctrl_pkg.sv
// Shared definitions for the pulse-generator run controller.
//   - command opcodes carried on cmd_op
//   - run FSM state encoding
//   - STATUS response field layout (depends on the channel count)
package pg_ctrl_pkg;

    localparam logic [2:0] OP_SET_LIMIT = 3'd0;
    localparam logic [2:0] OP_START     = 3'd1;
    localparam logic [2:0] OP_STOP      = 3'd2;
    localparam logic [2:0] OP_CLEAR     = 3'd3;
    localparam logic [2:0] OP_READ_CNT  = 3'd4;
    localparam logic [2:0] OP_STATUS    = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // STATUS word, LSB first: reached[n_ch-1:0], state[1:0], err, zeros.
    localparam int ST_REACHED_LSB = 0;
    localparam int ST_STATE_W     = 2;

    function automatic int st_state_lsb(input int n_ch);
        return n_ch;
    endfunction

    function automatic int st_err_bit(input int n_ch);
        return n_ch + ST_STATE_W;
    endfunction

endpackage

// File: rtl/pg_chan_cnt.sv
// One pulse channel: output gate plus saturating pulse counter.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clr         synchronous zero of the counter (wins over counting)
//   en          controller is in RUN
//   pulse_in    raw 1-cycle pulse from the generator
//   limit       pulse limit, 0 = unlimited
//   cnt         pulses emitted so far
//   reached     limit is nonzero and cnt equals it
//   pulse_out   gated pulse (combinational)
module pg_chan_cnt #(
    parameter int P_CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic               pulse_in,
    input  logic [P_CNT_W-1:0] limit,
    output logic [P_CNT_W-1:0] cnt,
    output logic               reached,
    output logic               pulse_out
);

    logic [P_CNT_W-1:0] cnt_q;

    assign reached = (limit != '0) && (cnt_q == limit);

    // Blocking at all-ones makes the counter saturate instead of wrapping,
    // and keeps every emitted pulse accounted for in cnt.
    assign pulse_out = pulse_in && en && !reached && (cnt_q != '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (pulse_out) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pg_run_ctrl.sv
// Run controller for the LFSR pulse-generator bank. Decodes commands,
// holds per-channel limits, runs the IDLE/ARM/RUN/DONE FSM, gates each raw
// pulse through a pg_chan_cnt and returns counts/status as responses.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_ch, cmd_data      opcode, channel, SET_LIMIT operand
//   rsp_valid/rsp_ready, rsp_data response handshake and word
//   pulse_in, pulse_out           raw and gated pulses per channel
//   running, done                 FSM in RUN / in DONE
//
// Handshakes: a word transfers on the rising edge where valid && ready are
// both high. The producer holds valid and its payload until that edge. Only
// one response may be outstanding, so cmd_ready is low while rsp_valid is
// high; rsp_data is a register and therefore stable until consumed.
module pg_run_ctrl
    import pg_ctrl_pkg::*;
#(
    parameter int P_N_CH  = 8,
    parameter int P_CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [2:0]         cmd_ch,
    input  logic [P_CNT_W-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [P_CNT_W-1:0] rsp_data,
    input  logic [P_N_CH-1:0]  pulse_in,
    output logic [P_N_CH-1:0]  pulse_out,
    output logic               running,
    output logic               done
);

    localparam int ST_STATE_LSB = st_state_lsb(P_N_CH);
    localparam int ST_ERR_BIT   = st_err_bit(P_N_CH);

    state_t             state_q, state_d;
    logic               err_q;
    logic [P_CNT_W-1:0] limit_q [P_N_CH];
    logic [P_CNT_W-1:0] cnt_w   [P_N_CH];
    logic [P_N_CH-1:0]  reached_w;
    logic [P_N_CH-1:0]  limit_nz;
    logic               rsp_valid_q;
    logic [P_CNT_W-1:0] rsp_data_q;

    logic               cmd_fire;
    logic               ch_ok;
    logic               cfg_state;
    logic               is_set, is_start, is_stop, is_clear, is_read, is_status;
    logic               lim_we, err_set, cnt_clr, all_done;
    logic [P_CNT_W-1:0] rd_cnt, status_w;

    assign cmd_ready = !rsp_valid_q;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign ch_ok     = int'(cmd_ch) < P_N_CH;
    assign cfg_state = (state_q == S_IDLE) || (state_q == S_DONE);

    assign is_set    = cmd_fire && (cmd_op == OP_SET_LIMIT);
    assign is_start  = cmd_fire && (cmd_op == OP_START);
    assign is_stop   = cmd_fire && (cmd_op == OP_STOP);
    assign is_clear  = cmd_fire && (cmd_op == OP_CLEAR);
    assign is_read   = cmd_fire && (cmd_op == OP_READ_CNT);
    assign is_status = cmd_fire && (cmd_op == OP_STATUS);

    assign lim_we  = is_set && ch_ok && cfg_state;
    assign err_set = (is_set && !cfg_state)
                   || (cmd_fire && (cmd_op > OP_STATUS))
                   || ((is_set || is_read) && !ch_ok);

    // Counters are zeroed while passing through ARM and on CLEAR.
    assign cnt_clr = (state_q == S_ARM) || is_clear;

    always_comb begin
        limit_nz = '0;
        for (int i = 0; i < P_N_CH; i++) begin
            limit_nz[i] = (limit_q[i] != '0);
        end
    end

    // Unlimited channels never block completion; at least one limit must
    // be set, otherwise a run with all limits 0 would finish instantly.
    assign all_done = (|limit_nz) && (&(reached_w | ~limit_nz));

    genvar g;
    generate
        for (g = 0; g < P_N_CH; g++) begin : g_ch
            pg_chan_cnt #(.P_CNT_W(P_CNT_W)) u_cnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .clr       (cnt_clr),
                .en        (state_q == S_RUN),
                .pulse_in  (pulse_in[g]),
                .limit     (limit_q[g]),
                .cnt       (cnt_w[g]),
                .reached   (reached_w[g]),
                .pulse_out (pulse_out[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (is_clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (is_start) state_d = S_ARM;
                S_ARM:   state_d = S_RUN;
                S_RUN: begin
                    if (is_stop)       state_d = S_IDLE;
                    else if (all_done) state_d = S_DONE;
                end
                S_DONE:  if (is_start) state_d = S_ARM;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A fresh error in the same cycle as ARM still sticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (state_q == S_ARM) begin
            err_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P_N_CH; i++) limit_q[i] <= '0;
        end else begin
            for (int i = 0; i < P_N_CH; i++) begin
                if (lim_we && (cmd_ch == 3'(i))) limit_q[i] <= cmd_data;
            end
        end
    end

    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < P_N_CH; i++) begin
            if (cmd_ch == 3'(i)) rd_cnt = cnt_w[i];
        end
    end

    always_comb begin
        status_w = '0;
        status_w[ST_REACHED_LSB +: P_N_CH]     = reached_w;
        status_w[ST_STATE_LSB +: ST_STATE_W] = state_q;
        status_w[ST_ERR_BIT]                   = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else if (is_read) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= ch_ok ? rd_cnt : '0;
        end else if (is_status) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= status_w;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign running   = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_pg_run_ctrl.sv
// Directed bench for pg_run_ctrl: gating, limits, STOP timing, sticky err,
// counter saturation and asynchronous reset.
module tb_pg_run_ctrl;
    import pg_ctrl_pkg::*;

    localparam int N = 8;
    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [2:0]    cmd_ch;
    logic [W-1:0]  cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic [N-1:0]  pulse_in;
    logic [N-1:0]  pulse_out;
    logic          running;
    logic          done;

    logic [W-1:0]  exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    pg_run_ctrl #(.P_N_CH(N), .P_CNT_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ch    (cmd_ch),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .pulse_in  (pulse_in),
        .pulse_out (pulse_out),
        .running   (running),
        .done      (done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called in the low phase; returns at the negedge after acceptance.
    task automatic send_cmd(input logic [2:0] op, input logic [2:0] ch, input logic [W-1:0] data);
        int k;
        k = 0;
        cmd_op    = op;
        cmd_ch    = ch;
        cmd_data  = data;
        cmd_valid = 1'b1;
        while (!cmd_ready && k < 20) begin
            tick();
            k++;
        end
        if (!cmd_ready) chk("cmd_ready_wait", W'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag);
        logic [W-1:0] e;
        int k;
        e = exp_q.pop_front();
        k = 0;
        while (!rsp_valid && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_valid"}, W'(rsp_valid), 1);
        chk(tag, rsp_data, e);
        tick();
        chk({tag, "_hold"}, rsp_data, e);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic read_cnt(input logic [2:0] ch, input logic [W-1:0] e, input string tag);
        exp_q.push_back(e);
        send_cmd(OP_READ_CNT, ch, '0);
        get_rsp(tag);
    endtask

    task automatic read_status(input logic [W-1:0] e, input string tag);
        exp_q.push_back(e);
        send_cmd(OP_STATUS, 3'd0, '0);
        get_rsp(tag);
    endtask

    // ---------------- directed sequence ----------------
    int          n_pass;
    int          fifth_idx;
    int          first_done;
    logic [2:0]  pass_bits;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_ch    = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        pulse_in  = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset values
        chk("rst_cmd_ready", W'(cmd_ready), 1);
        chk("rst_rsp_valid", W'(rsp_valid), 0);
        chk("rst_rsp_data",  rsp_data, 0);
        chk("rst_pulse_out", W'(pulse_out), 0);
        chk("rst_running",   W'(running), 0);
        chk("rst_done",      W'(done), 0);
        rst_n = 1'b1;
        tick();

        read_status(32'h0, "status_after_reset");

        // Pulses in IDLE never pass
        for (int i = 0; i < 10; i++) begin
            pulse_in = '1;
            #1;
            chk("idle_gate", W'(pulse_out), 0);
            tick();
        end
        pulse_in = '0;

        // Limit 5 on ch0, ten pulses offered
        send_cmd(OP_SET_LIMIT, 3'd0, 32'd5);
        send_cmd(OP_START, 3'd0, '0);
        n_pass = 0;
        fifth_idx = -1;
        first_done = -1;
        for (int i = 0; i < 10; i++) begin
            pulse_in = 8'h01;
            #1;
            if (i == 0) chk("arm_not_running", W'(running), 0);
            if (i == 1) chk("run_entered", W'(running), 1);
            if (pulse_out[0]) begin
                n_pass++;
                if (n_pass == 5) fifth_idx = i;
            end
            if (done && first_done < 0) first_done = i;
            tick();
        end
        pulse_in = '0;
        chk("limit5_passes", W'(n_pass), 5);
        chk("limit5_fifth_cycle", W'(fifth_idx), 5);
        chk("limit5_done_cycle", W'(first_done), 7);
        read_cnt(3'd0, 32'd5, "limit5_cnt");
        read_status(32'h301, "limit5_status");

        // Unlimited run, 100 pulses on ch3
        send_cmd(OP_CLEAR, 3'd0, '0);
        send_cmd(OP_SET_LIMIT, 3'd0, 32'd0);
        send_cmd(OP_START, 3'd0, '0);
        tick();
        for (int i = 0; i < 100; i++) begin
            pulse_in = 8'h08;
            tick();
        end
        pulse_in = '0;
        chk("unlim_running", W'(running), 1);
        chk("unlim_not_done", W'(done), 0);
        read_cnt(3'd3, 32'd100, "unlim_cnt_run");
        send_cmd(OP_STOP, 3'd0, '0);
        chk("stop_idle", W'(running), 0);
        read_cnt(3'd3, 32'd100, "unlim_cnt_stopped");
        read_status(32'h0, "stopped_status");

        // STOP together with a ch1 pulse
        send_cmd(OP_START, 3'd0, '0);
        tick();
        cmd_op    = OP_STOP;
        cmd_ch    = 3'd0;
        cmd_valid = 1'b1;
        pulse_in  = 8'h02;
        #1;
        chk("stop_edge_pulse_passes", W'(pulse_out), 32'h02);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("after_stop_blocked", W'(pulse_out), 0);
        chk("after_stop_idle", W'(running), 0);
        pulse_in = '0;
        read_cnt(3'd1, 32'd1, "stop_edge_counted");
        read_cnt(3'd3, 32'd0, "arm_zeroed_ch3");

        // SET_LIMIT during RUN is rejected and flags err
        send_cmd(OP_SET_LIMIT, 3'd2, 32'd3);
        send_cmd(OP_START, 3'd0, '0);
        tick();
        send_cmd(OP_SET_LIMIT, 3'd2, 32'd7);
        read_status(32'h600, "err_in_run_status");
        n_pass = 0;
        for (int i = 0; i < 5; i++) begin
            pulse_in = 8'h04;
            #1;
            if (pulse_out[2]) n_pass++;
            tick();
        end
        pulse_in = '0;
        chk("limit_kept_passes", W'(n_pass), 3);
        chk("limit_kept_done", W'(done), 1);
        read_status(32'h704, "done_err_status");
        send_cmd(OP_START, 3'd0, '0);
        tick();
        read_status(32'h200, "restart_err_cleared");

        // Saturation on ch5 from a preloaded near-max count
        send_cmd(OP_CLEAR, 3'd0, '0);
        send_cmd(OP_SET_LIMIT, 3'd2, 32'd0);
        send_cmd(OP_START, 3'd0, '0);
        tick();
        force dut.g_ch[5].u_cnt.cnt_q = 32'hFFFF_FFFD;
        tick();
        release dut.g_ch[5].u_cnt.cnt_q;
        pass_bits = '0;
        for (int i = 0; i < 3; i++) begin
            pulse_in = 8'h20;
            #1;
            pass_bits[i] = pulse_out[5];
            tick();
        end
        pulse_in = '0;
        chk("sat_pass_pattern", W'(pass_bits), 32'h3);
        read_cnt(3'd5, 32'hFFFF_FFFF, "sat_cnt");

        // Asynchronous reset mid-run with a response pending
        send_cmd(OP_READ_CNT, 3'd0, '0);
        chk("pending_rsp_valid", W'(rsp_valid), 1);
        chk("pending_cmd_ready", W'(cmd_ready), 0);
        pulse_in = 8'h01;
        #1;
        chk("prereset_pulse", W'(pulse_out), 32'h01);
        rst_n = 1'b0;
        #1;
        chk("arst_cmd_ready", W'(cmd_ready), 1);
        chk("arst_rsp_valid", W'(rsp_valid), 0);
        chk("arst_rsp_data",  rsp_data, 0);
        chk("arst_pulse_out", W'(pulse_out), 0);
        chk("arst_running",   W'(running), 0);
        chk("arst_done",      W'(done), 0);
        pulse_in = '0;
        tick();
        rst_n = 1'b1;
        tick();
        read_status(32'h0, "post_arst_status");
        read_cnt(3'd5, 32'd0, "post_arst_cnt");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
